// File: rtl/dla_mov_gb2lb_pkg.sv
// Shared types and widths for the GB-to-LB move engine.
// The descriptor is captured on go; the state enum is shared with a future LB2GB mover.
package dla_mov_gb2lb_pkg;

    localparam int unsigned GB_AW  = 13;
    localparam int unsigned LB_AW  = 11;
    localparam int unsigned LB_SKW = 6;
    localparam int unsigned ITW    = 6;

    typedef struct packed {
        logic [GB_AW-1:0]  gb_addr;
        logic [GB_AW-1:0]  gb_skip;
        logic [LB_AW-1:0]  lb_addr;
        logic [LB_SKW-1:0] lb_skip;
        logic [GB_AW-1:0]  len;
        logic [ITW-1:0]    iter;
    } MOV_GB2LB_DESC_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } MOV_STATE_e;

    // A descriptor with no words skips straight to completion.
    function automatic logic desc_is_empty(input MOV_GB2LB_DESC_t d);
        return (d.len == '0) || (d.iter == '0);
    endfunction

endpackage

// File: rtl/dla_mov_addr_pipe.sv
// Fixed-latency delay line carrying a valid tag and a destination address,
// aligned so its output pairs with read data returning LAT cycles after accept.
module dla_mov_addr_pipe #(
    parameter int unsigned LAT = 2,
    parameter int unsigned AW  = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_addr,
    output logic          o_vld,
    output logic [AW-1:0] o_addr
);

    logic [LAT-1:0] r_vld;
    logic [AW-1:0]  r_addr [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_push;
            r_addr[0] <= i_addr;
            for (int i = 1; i < int'(LAT); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[LAT-1];
    assign o_addr = r_addr[LAT-1];

endmodule

// File: rtl/dla_mov_gb2lb.sv
// GB-to-LB move engine: strided GB reads through a req/gnt port, returned words
// written to strided LB addresses; reports busy, done and dropped-go pulses.
module dla_mov_gb2lb
    import dla_mov_gb2lb_pkg::*;
#(
    parameter int unsigned DW        = 64,
    parameter int unsigned GB_RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_mov_gb2lb,
    input  logic [GB_AW-1:0]  stgr_gb2lb_gb_addr,
    input  logic [GB_AW-1:0]  stgr_gb2lb_gb_skip,
    input  logic [LB_AW-1:0]  stgr_gb2lb_lb_addr,
    input  logic [LB_SKW-1:0] stgr_gb2lb_lb_skip,
    input  logic [GB_AW-1:0]  stgr_gb2lb_len,
    input  logic [ITW-1:0]    stgr_gb2lb_iter,
    output logic              gb_rd_req,
    output logic [GB_AW-1:0]  gb_rd_addr,
    input  logic              gb_rd_gnt,
    input  logic              gb_rd_vld,
    input  logic [DW-1:0]     gb_rd_data,
    output logic              lb_wr_en,
    output logic [LB_AW-1:0]  lb_wr_addr,
    output logic [DW-1:0]     lb_wr_data,
    output logic              mov_busy,
    output logic              mov_done,
    output logic              mov_go_drop
);

    localparam int unsigned OW = $clog2(GB_RD_LAT + 1);

    MOV_STATE_e        r_state;
    MOV_GB2LB_DESC_t   r_desc;
    logic [GB_AW-1:0]  r_word;
    logic [ITW-1:0]    r_row;
    logic [GB_AW-1:0]  r_gb_off;
    logic [LB_AW-1:0]  r_lb_off;
    logic [GB_AW-1:0]  r_gb_addr;
    logic [LB_AW-1:0]  r_lb_addr;
    logic [OW-1:0]     r_outst;
    logic              r_rd_req;
    logic              r_busy;
    logic              r_done;
    logic              r_drop;
    logic              r_wr_en;
    logic [LB_AW-1:0]  r_wr_addr;
    logic [DW-1:0]     r_wr_data;

    MOV_GB2LB_DESC_t   w_in_desc;
    logic              w_accept;
    logic              w_pipe_vld;
    logic [LB_AW-1:0]  w_pipe_addr;
    logic              w_pop;
    logic              w_last_word;
    logic              w_last_row;
    logic [GB_AW-1:0]  w_gb_row_off;
    logic [LB_AW-1:0]  w_lb_row_off;

    always_comb begin
        w_in_desc         = '0;
        w_in_desc.gb_addr = stgr_gb2lb_gb_addr;
        w_in_desc.gb_skip = stgr_gb2lb_gb_skip;
        w_in_desc.lb_addr = stgr_gb2lb_lb_addr;
        w_in_desc.lb_skip = stgr_gb2lb_lb_skip;
        w_in_desc.len     = stgr_gb2lb_len;
        w_in_desc.iter    = stgr_gb2lb_iter;
    end

    assign w_accept     = r_rd_req && gb_rd_gnt;
    assign w_pop        = gb_rd_vld && w_pipe_vld;
    assign w_last_word  = (r_word == (r_desc.len - GB_AW'(1)));
    assign w_last_row   = (r_row == (r_desc.iter - ITW'(1)));
    assign w_gb_row_off = r_gb_off + r_desc.gb_skip;
    assign w_lb_row_off = r_lb_off + LB_AW'(r_desc.lb_skip);

    // LB destination of each accepted read rides alongside the GB latency.
    dla_mov_addr_pipe #(
        .LAT (GB_RD_LAT),
        .AW  (LB_AW)
    ) u_addr_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_accept),
        .i_addr (r_lb_addr),
        .o_vld  (w_pipe_vld),
        .o_addr (w_pipe_addr)
    );

    // Sequencer: descriptor capture, address walk and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_desc    <= '0;
            r_word    <= '0;
            r_row     <= '0;
            r_gb_off  <= '0;
            r_lb_off  <= '0;
            r_gb_addr <= '0;
            r_lb_addr <= '0;
            r_rd_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= go_mov_gb2lb && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (go_mov_gb2lb) begin
                        r_desc    <= w_in_desc;
                        r_word    <= '0;
                        r_row     <= '0;
                        r_gb_off  <= '0;
                        r_lb_off  <= '0;
                        r_gb_addr <= stgr_gb2lb_gb_addr;
                        r_lb_addr <= stgr_gb2lb_lb_addr;
                        r_busy    <= 1'b1;
                        if (desc_is_empty(w_in_desc)) begin
                            r_state <= DONE;
                        end else begin
                            r_state  <= RD;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            r_word    <= '0;
                            r_row     <= r_row + ITW'(1);
                            r_gb_off  <= w_gb_row_off;
                            r_lb_off  <= w_lb_row_off;
                            r_gb_addr <= r_desc.gb_addr + w_gb_row_off;
                            r_lb_addr <= r_desc.lb_addr + w_lb_row_off;
                            if (w_last_row) begin
                                r_state  <= DRAIN;
                                r_rd_req <= 1'b0;
                            end
                        end else begin
                            r_word    <= r_word + GB_AW'(1);
                            r_gb_addr <= r_gb_addr + GB_AW'(1);
                            r_lb_addr <= r_lb_addr + LB_AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Counter reaches zero on the edge that registers the last LB write.
                    if (r_outst == '0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Reads in flight between GB accept and data return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outst <= r_outst + OW'(1);
                2'b01:   r_outst <= r_outst - OW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    // LB write stage; data without a valid tag is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= w_pipe_addr;
                r_wr_data <= gb_rd_data;
            end
        end
    end

    a_vld_has_tag: assert property (@(posedge clk) disable iff (rst) gb_rd_vld |-> w_pipe_vld);

    assign gb_rd_req   = r_rd_req;
    assign gb_rd_addr  = r_gb_addr;
    assign lb_wr_en    = r_wr_en;
    assign lb_wr_addr  = r_wr_addr;
    assign lb_wr_data  = r_wr_data;
    assign mov_busy    = r_busy;
    assign mov_done    = r_done;
    assign mov_go_drop = r_drop;

endmodule
